// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial-link channel scheduler.
// Holds the requester count, the index of each AXI channel stream,
// the per-requester credit depth and the derived counter/id types.
package serial_link_pkg;

  localparam int NumReq     = 5;
  localparam int NumCredits = 8;
  localparam int CreditW    = $clog2(NumCredits + 1);
  localparam int IdW        = $clog2(NumReq);

  // Requester index order on the shared payload path.
  localparam int ChanAw = 0;
  localparam int ChanW  = 1;
  localparam int ChanB  = 2;
  localparam int ChanAr = 3;
  localparam int ChanR  = 4;

  typedef logic [CreditW-1:0] credit_cnt_t;
  typedef logic [IdW-1:0]     chan_id_t;

endpackage

// File: rtl/serial_link_credit_cnt.sv
// Per-requester credit counter mirroring free slots in the remote FIFO.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   clr_i         re-initialise to NumCredits (link retrain), wins over inc/dec
//   dec_i         a beat was granted this cycle
//   inc_i         one credit returned this cycle
//   count_o       current credit count
//   nonzero_o     at least one credit available
//   ovf_o         pulse: return arrived while already full (and no grant)
module serial_link_credit_cnt
  import serial_link_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        dec_i,
  input  logic        inc_i,
  output credit_cnt_t count_o,
  output logic        nonzero_o,
  output logic        ovf_o
);

  credit_cnt_t count_q;
  logic        at_max;

  assign at_max = (count_q == credit_cnt_t'(NumCredits));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= credit_cnt_t'(NumCredits);
    end else if (dec_i && !inc_i) begin
      // Grant only happens when nonzero_o is set, so this never wraps.
      count_q <= count_q - credit_cnt_t'(1);
    end else if (inc_i && !dec_i && !at_max) begin
      count_q <= count_q + credit_cnt_t'(1);
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = (count_q != '0);
  // A simultaneous grant cancels the return, so that case is not an overflow.
  assign ovf_o     = inc_i & ~dec_i & at_max & ~clr_i;

endmodule

// File: rtl/serial_link_chan_sched.sv
// Credit-based round-robin scheduler sharing the serial-link payload path
// between the AW, W, B, AR and R streams.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_valid_i      per-requester beat valid
//   req_ready_o      per-requester beat accepted (one-hot, combinational)
//   req_data_i       per-requester payload
//   link_valid_o     output register holds a beat
//   link_ready_i     link accepts the beat
//   link_data_o      output payload
//   link_id_o        requester index of the output beat
//   chan_en_i        requester enable from config registers
//   credit_ret_i     one-credit return pulse per requester
//   credit_reset_i   re-initialise all credits, clear credit_err_o
//   credits_o        registered credit count per requester
//   credit_err_o     sticky: credit returned while counter was full
module serial_link_chan_sched
  import serial_link_pkg::*;
#(
  parameter int PayloadWidth = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic        [NumReq-1:0]              req_valid_i,
  output logic        [NumReq-1:0]              req_ready_o,
  input  logic        [NumReq-1:0][PayloadWidth-1:0] req_data_i,
  output logic                                  link_valid_o,
  input  logic                                  link_ready_i,
  output logic        [PayloadWidth-1:0]        link_data_o,
  output chan_id_t                              link_id_o,
  input  logic        [NumReq-1:0]              chan_en_i,
  input  logic        [NumReq-1:0]              credit_ret_i,
  input  logic                                  credit_reset_i,
  output credit_cnt_t [NumReq-1:0]              credits_o,
  output logic                                  credit_err_o
);

  logic [NumReq-1:0] nonzero;
  logic [NumReq-1:0] ovf;
  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] grant;
  logic              pick_any;
  chan_id_t          pick_id;
  chan_id_t          rr_ptr_q;
  chan_id_t          rr_next;
  logic              out_free;
  int                idx;

  // Reset and credit re-initialisation both block new grants.
  assign eligible = req_valid_i & chan_en_i & nonzero
                  & {NumReq{~credit_reset_i & ~rst_i}};
  assign out_free = ~link_valid_o | link_ready_i;

  // Priority search over eligible requesters, rotated to start at rr_ptr.
  // NOTE: every variable gets a default before any conditional write so the
  // block stays purely combinational (no latch).
  always_comb begin
    pick_any = 1'b0;
    pick_id  = '0;
    idx      = 0;
    grant    = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(rr_ptr_q) + k) % NumReq;
      if (!pick_any && eligible[idx]) begin
        pick_any = 1'b1;
        pick_id  = chan_id_t'(idx);
      end
    end
    if (pick_any && out_free) grant[pick_id] = 1'b1;
  end

  assign req_ready_o = grant;
  assign rr_next     = (pick_id == chan_id_t'(NumReq - 1)) ? '0
                                                           : pick_id + chan_id_t'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      link_valid_o <= 1'b0;
      link_data_o  <= '0;
      link_id_o    <= '0;
      rr_ptr_q     <= '0;
    end else if (out_free) begin
      // A stalled beat (valid & !ready) never enters this branch, so the
      // payload and id are held until the link takes them.
      link_valid_o <= pick_any;
      if (pick_any) begin
        link_data_o <= req_data_i[pick_id];
        link_id_o   <= pick_id;
        rr_ptr_q    <= rr_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || credit_reset_i) begin
      credit_err_o <= 1'b0;
    end else if (|ovf) begin
      credit_err_o <= 1'b1;
    end
  end

  for (genvar i = 0; i < NumReq; i++) begin : g_credit
    serial_link_credit_cnt u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (credit_reset_i),
      .dec_i     (grant[i]),
      .inc_i     (credit_ret_i[i]),
      .count_o   (credits_o[i]),
      .nonzero_o (nonzero[i]),
      .ovf_o     (ovf[i])
    );
  end

endmodule
